booth_multiplier_seq: RTL and testbench
=======================================

Name: booth_multiplier_seq

Overview:
- Parametrised successor to the fixed 8-bit Booth multiplier subsystem. It is a sequential radix-2 Booth multiplier with WIDTH-bit operands and a 2*WIDTH-bit product.
- Adds a per-operation signed/unsigned mode, valid/ready handshakes on input and output, and result hold under back-pressure.
- Sits between the operand-capture logic and the result display/consumer path.

Parameters:
- WIDTH, 8, operand width in bits; legal range is 4 to 32.
- CNT_W, $clog2(WIDTH+2), iteration counter width. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept an operation.
- signed_mode  in  1  1 = two's-complement operands; 0 = unsigned operands.
- num_1  in  WIDTH  multiplicand.
- num_2  in  WIDTH  multiplier.
- result_valid  out  1  product is available.
- result_ready  in  1  consumer accepts the product.
- mult  out  2*WIDTH  product.
- busy  out  1  high when state is RUN.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All datapath registers clear.
  - Outputs: in_ready=1 after reset deasserts, result_valid=0, mult=0, busy=0.
- Internal operand width is N=WIDTH+1.
  - signed_mode=1: operands are sign-extended.
  - signed_mode=0: operands are zero-extended.
- Registers:
  - M: N bits.
  - A: N bits.
  - Q: N bits.
  - Qprev: 1 bit.
  - cnt: CNT_W bits.
- State IDLE:
  - in_ready=1.
  - On a clock edge with in_valid&in_ready:
    - M and Q load the extended num_1 and num_2; mode is sampled at this point only.
    - A=0, Qprev=0, cnt=N.
    - Next state is RUN.
- State RUN (one Booth step per cycle; add/sub and shift happen in the same cycle):
  - {Q[0],Qprev}=01: A=A+M. 10: A=A-M. 00 or 11: no add.
  - After the add step, arithmetic right shift of {A,Q,Qprev} by 1. The arithmetic is N bits with wrap.
  - cnt decrements each cycle. When cnt reaches 1, the step executes and the next state is DONE.
  - in_ready=0 and inputs are ignored.
- State DONE:
  - result_valid=1.
  - mult is the low 2*WIDTH bits of {A,Q}, held stable.
  - On result_ready=1: next state is IDLE and result_valid drops the following cycle.
  - While result_ready=0, the block stays in DONE indefinitely and mult does not change.
- Latency:
  - The accept edge is edge 0. result_valid is high after edge N, i.e. WIDTH+1 cycles (9 for WIDTH=8).
  - Back-to-back throughput is one op per N+2 cycles.
- mult after DONE:
  - mult keeps its last value in IDLE.
  - mult updates only on entry to DONE.
- Boundary cases:
  - Operands 0: normal run, mult=0.
  - Most-negative signed values are handled by the N-bit extension, so no overflow occurs.
  - in_valid held high through DONE is not accepted until IDLE.
  - Reset mid-RUN or in DONE aborts immediately and drops the result.
  - in_valid without in_ready: no effect.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined: the RUN state checks the unprocessed multiplier bits.
  - In RUN, if the remaining unprocessed bits of Q (the low cnt bits) and Qprev are all equal, every remaining step is shift-only.
  - In that case, a single cycle applies an arithmetic right shift of {A,Q,Qprev} by cnt and goes to DONE.
  - Results are identical to the full run; latency is shorter. Example: num_2=0 gives result_valid 1 cycle after accept.
- Undefined: latency is always exactly N cycles.
- The bench must pass in both builds. Latency checks are conditional on the macro.

Decomposition:
- Package booth_mult_pkg:
  - State enum: IDLE, RUN, DONE (2 bits).
  - Booth op enum: NOP, ADD, SUB.
  - Function booth_decode({Q0,Qprev}).
- Sub-module booth_mult_datapath:
  - Contains the M/A/Q/Qprev/cnt registers, extension, add/sub, and shift (plus the early-shift path).
  - Controlled by load/step/early strobes from the FSM in booth_multiplier_seq.
  - Returns Q[0], Qprev, cnt==1, and the early-term flag.

Test Plan (WIDTH=8):
- Signed, num_1=0x80 (-128), num_2=0x80 -> mult=0x4000; result_valid exactly 9 cycles after accept (macro off).
- Unsigned, num_1=0xFF, num_2=0xFF -> mult=0xFE01. Signed, same operands (-1*-1) -> mult=0x0001.
- Signed, num_1=0x07, num_2=0xFD (-3), with result_ready held 0 for 20 cycles -> mult=0xFFEB stable, result_valid held, in_ready=0; after result_ready pulse, IDLE and in_ready=1.
- Start an op, assert reset low at RUN cycle 4 -> result_valid=0, mult=0, in_ready=1 after release. Next op 5*6 -> mult=0x001E.
- Randomised 1000 ops with random mode and result_ready stalls vs. a reference model -> all match. With BOOTH_EARLY_TERM_EN, num_2=0 -> latency 1 and mult=0.

Source files
------------

// File: rtl/booth_mult_pkg.sv
// -----------------------------------------------------------------------------
// booth_mult_pkg
// Shared definitions for the sequential radix-2 Booth multiplier.
//   - FSM state encodings (IDLE / RUN / DONE), 2 bits wide
//   - Booth operation enum (NOP / ADD / SUB)
//   - booth_decode(): maps the {Q[0], Qprev} bit pair to a Booth operation
// Optional feature macro used by this slice: BOOTH_EARLY_TERM_EN
// -----------------------------------------------------------------------------
package booth_mult_pkg;

    // Controller state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit and the previous one.
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        booth_op_t op;
        case (pair)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_datapath.sv
// -----------------------------------------------------------------------------
// booth_mult_datapath
// Holds the Booth working registers (M, A, Q, Qprev, cnt) and the product
// register. Operands are widened to N = WIDTH+1 bits (sign- or zero-extended
// according to signed_mode) so the most-negative signed value and full-range
// unsigned values both fit without overflow.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   load              capture extended operands, clear A/Qprev, cnt = N
//   step              one Booth add/sub + arithmetic right shift
//   early_take        collapse all remaining shift-only steps into one cycle
//   op                Booth operation for the current step
//   signed_mode       operand interpretation, sampled on load only
//   num_1, num_2      multiplicand, multiplier
//   q0, q_prev        current Booth pair, for the controller's decoder
//   cnt_one           current step is the last one
//   early_flag        remaining steps are all shift-only
//   prod              product register, updated only when the last step retires
// Feature macro: BOOTH_EARLY_TERM_EN (without it, early_flag is tied low)
// -----------------------------------------------------------------------------
module booth_mult_datapath
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               early_take,
    input  booth_op_t          op,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   num_1,
    input  logic [WIDTH-1:0]   num_2,
    output logic               q0,
    output logic               q_prev,
    output logic               cnt_one,
    output logic               early_flag,
    output logic [2*WIDTH-1:0] prod
);

    localparam int N = WIDTH + 1;

    logic [N-1:0]     m;
    logic [N-1:0]     a;
    logic [N-1:0]     q;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0] ext_1;
    logic [N-1:0] ext_2;
    logic [N-1:0] sum;
    logic [N-1:0] a_step;
    logic [N-1:0] q_step;

    assign ext_1 = signed_mode ? {num_1[WIDTH-1], num_1} : {1'b0, num_1};
    assign ext_2 = signed_mode ? {num_2[WIDTH-1], num_2} : {1'b0, num_2};

    // Add/subtract and the 1-bit arithmetic shift of {A,Q,Qprev} in one cycle.
    always_comb begin
        sum = a;
        case (op)
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
        a_step = {sum[N-1], sum[N-1:1]};
        q_step = {sum[0], q[N-1:1]};
    end

    assign q0      = q[0];
    assign cnt_one = (cnt == CNT_W'(1));

`ifdef BOOTH_EARLY_TERM_EN
    logic [2*N:0] wide_sh;
    logic [N:0]   mask;
    logic [N:0]   rem;

    // When the low cnt bits of Q all equal Qprev, every remaining Booth pair
    // decodes to NOP, so the rest of the run is just a shift by cnt.
    always_comb begin
        wide_sh    = $signed({a, q, q_prev}) >>> cnt;
        mask       = ((N+1)'(1) << cnt) - (N+1)'(1);
        rem        = {1'b0, q} & mask;
        early_flag = q_prev ? (rem == mask) : (rem == '0);
    end
`else
    assign early_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m      <= '0;
            a      <= '0;
            q      <= '0;
            q_prev <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
        end else if (load) begin
            m      <= ext_1;
            a      <= '0;
            q      <= ext_2;
            q_prev <= 1'b0;
            cnt    <= CNT_W'(N);
`ifdef BOOTH_EARLY_TERM_EN
        end else if (early_take) begin
            {a, q, q_prev} <= wide_sh;
            cnt            <= '0;
            prod           <= wide_sh[2*WIDTH:1];
`endif
        end else if (step) begin
            a      <= a_step;
            q      <= q_step;
            q_prev <= q[0];
            cnt    <= cnt - CNT_W'(1);
            if (cnt_one) begin
                prod <= {a_step[WIDTH-2:0], q_step};
            end
        end
    end

`ifndef BOOTH_EARLY_TERM_EN
    // early_take is always low in this build.
    logic unused_early;
    assign unused_early = early_take;
`endif

endmodule

// File: rtl/booth_multiplier_seq.sv
// -----------------------------------------------------------------------------
// booth_multiplier_seq
// Sequential radix-2 Booth multiplier, WIDTH-bit operands, 2*WIDTH-bit product,
// per-operation signed/unsigned mode and valid/ready handshakes.
// Handshake semantics: an operation is accepted on a rising edge where
// in_valid && in_ready (in_ready is high only in IDLE); a product is consumed
// on a rising edge where result_valid && result_ready (result_valid is high
// only in DONE). mult is held stable in DONE and keeps its value in IDLE.
// Ports:
//   clk, reset                clock, asynchronous active-low reset
//   in_valid / in_ready       operand handshake
//   signed_mode               1 = two's complement, 0 = unsigned
//   num_1, num_2              multiplicand, multiplier
//   result_valid/result_ready product handshake
//   mult                      product
//   busy                      high while in RUN
// Feature macro: BOOTH_EARLY_TERM_EN (skips trailing shift-only steps)
// -----------------------------------------------------------------------------
module booth_multiplier_seq
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   num_1,
    input  logic [WIDTH-1:0]   num_2,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [2*WIDTH-1:0] mult,
    output logic               busy
);

    logic [1:0] state;
    logic [1:0] state_nxt;

    logic      load;
    logic      step;
    logic      early_take;
    logic      q0;
    logic      q_prev;
    logic      cnt_one;
    logic      early_flag;
    booth_op_t op;

    assign op = booth_decode({q0, q_prev});

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        step       = 1'b0;
        early_take = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (early_flag) begin
                    early_take = 1'b1;
                    state_nxt  = DONE;
                end else begin
                    step = 1'b1;
                    if (cnt_one) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign in_ready     = (state == IDLE);
    assign result_valid = (state == DONE);
    assign busy         = (state == RUN);

    booth_mult_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .step        (step),
        .early_take  (early_take),
        .op          (op),
        .signed_mode (signed_mode),
        .num_1       (num_1),
        .num_2       (num_2),
        .q0          (q0),
        .q_prev      (q_prev),
        .cnt_one     (cnt_one),
        .early_flag  (early_flag),
        .prod        (mult)
    );

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_multiplier_seq
// Directed and randomised checks of booth_multiplier_seq at WIDTH=8.
// Feature macro: BOOTH_EARLY_TERM_EN selects the expected latencies.
// -----------------------------------------------------------------------------
module tb_booth_multiplier_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           signed_mode = 1'b0;
    logic           result_ready = 1'b0;
    logic [W-1:0]   num_1 = '0;
    logic [W-1:0]   num_2 = '0;
    logic           in_ready;
    logic           result_valid;
    logic           busy;
    logic [2*W-1:0] mult;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_v;

    booth_multiplier_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .signed_mode  (signed_mode),
        .num_1        (num_1),
        .num_2        (num_2),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .mult         (mult),
        .busy         (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mult(input logic mode, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        longint p;
        logic [63:0] pv;
        if (mode) p = longint'($signed(x)) * longint'($signed(y));
        else      p = longint'({56'd0, x}) * longint'({56'd0, y});
        pv = p;
        return pv[2*W-1:0];
    endfunction

    task automatic check_lat(input string tag, input int got, input int full_lat, input int early_lat);
`ifdef BOOTH_EARLY_TERM_EN
        check(tag, got, early_lat);
`else
        check(tag, got, full_lat);
`endif
    endtask

    // ---------------- drivers ----------------
    // Present an operation; called #1 after a rising edge while IDLE.
    task automatic start_op(input logic mode, input logic [W-1:0] x, input logic [W-1:0] y,
                            input bit hold_valid);
        signed_mode = mode;
        num_1       = x;
        num_2       = y;
        in_valid    = 1'b1;
        check("accept_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        if (hold_valid) begin
            // Keep requesting with different operands; must be ignored.
            num_1 = 8'h33;
            num_2 = 8'h44;
        end else begin
            in_valid = 1'b0;
        end
        check("run_busy", busy, 1);
        check("run_in_ready", in_ready, 0);
    endtask

    // Count edges after the accept edge until result_valid is seen.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!result_valid && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!result_valid) check("done_timeout", 0, 1);
    endtask

    task automatic consume(input logic [2*W-1:0] exp);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check("post_consume_valid", result_valid, 0);
        check("post_consume_in_ready", in_ready, 1);
        check("idle_mult_hold", mult, exp);
    endtask

    task automatic run_directed(input string tag, input logic mode, input logic [W-1:0] x,
                                input logic [W-1:0] y, input logic [2*W-1:0] exp,
                                input int early_lat);
        int l;
        start_op(mode, x, y, 1'b0);
        wait_done(l);
        check(tag, mult, exp);
        check_lat({tag, "_lat"}, l, 9, early_lat);
        consume(exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_result_valid", result_valid, 0);
        check("rst_mult", mult, 0);
        check("rst_busy", busy, 0);

        // Directed vectors with hand-computed products and early-term latencies.
        run_directed("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000, 9);
        run_directed("u_ffxff",     1'b0, 8'hFF, 8'hFF, 16'hFE01, 9);
        run_directed("s_m1xm1",     1'b1, 8'hFF, 8'hFF, 16'h0001, 2);
        run_directed("s_127xm128",  1'b1, 8'h7F, 8'h80, 16'hC080, 9);
        run_directed("u_80x80",     1'b0, 8'h80, 8'h80, 16'h4000, 9);
        run_directed("u_55x00",     1'b0, 8'h55, 8'h00, 16'h0000, 1);
        run_directed("s_00x00",     1'b1, 8'h00, 8'h00, 16'h0000, 1);

        // 7 * -3 with in_valid held through RUN/DONE and result_ready stalled.
        start_op(1'b1, 8'h07, 8'hFD, 1'b1);
        wait_done(lat);
        check_lat("stall_lat", lat, 9, 4);
        check("stall_mult_first", mult, 16'hFFEB);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("stall_mult", mult, 16'hFFEB);
            check("stall_valid", result_valid, 1);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        consume(16'hFFEB);
        check("stall_idle_busy", busy, 0);

        // Reset in the middle of a run drops the operation.
        start_op(1'b1, 8'h12, 8'h34, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("midrun_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("abort_valid", result_valid, 0);
        check("abort_mult", mult, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", in_ready, 1);
        run_directed("u_5x6", 1'b0, 8'h05, 8'h06, 16'h001E, 5);

        // Reset while holding a result in DONE.
        start_op(1'b0, 8'h0B, 8'h0D, 1'b0);
        wait_done(lat);
        check("done_mult", mult, 16'h008F);
        reset = 1'b0;
        #1;
        check("done_abort_valid", result_valid, 0);
        check("done_abort_mult", mult, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Randomised operations against the reference product, with stalls.
        for (int n = 0; n < 1000; n++) begin
            logic       md;
            logic [W-1:0] x;
            logic [W-1:0] y;
            md = 1'($urandom_range(0, 1));
            x  = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
            y  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            exp_q.push_back(ref_mult(md, x, y));
            start_op(md, x, y, 1'b0);
            wait_done(lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            exp_v = exp_q.pop_front();
            check("rand_mult", mult, exp_v);
            consume(exp_v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
